tiny_dnn_stream_master: RTL and testbench
=========================================

// Module: tiny_dnn_stream_master
// PURPOSE
//  Host-side stream endpoint for the tiny_dnn accelerator. Holds input samples in a local src RAM,
//  transmits each sample as one src_* beat train (src_last on final word), then collects the
//  dst_* result burst into a local result RAM. Sits between host register/memory port and accelerator.
// PARAMETERS
//  AW           12     word address width of each RAM (2**AW words each)
//  DW           32     data word width (IEEE-754 single bit pattern)
//  TIMEOUT_CYC  65535  RECV idle cycles before error (TDNN_TIMEOUT_EN only)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  h_wr       in   1      host write strobe, src RAM only
//  h_rd       in   1      host read strobe, result RAM only
//  h_addr     in   AW     host word address
//  h_wdata    in   DW     host write data
//  h_rdata    out  DW     host read data, valid 1 cycle after h_rd
//  start      in   1      1-cycle pulse; begins batch when idle
//  ss         in   AW     last word index of one src sample (sample length ss+1)
//  ds         in   AW     last word index of one dst result (result length ds+1)
//  n_batch    in   8      samples per batch minus 1
//  busy       out  1      high from accepted start until done/err
//  done       out  1      1-cycle pulse after last result word stored
//  err        out  1      sticky timeout flag; cleared by next accepted start
//  src_valid  out  1      / src_data out DW / src_last out 1 / src_ready in 1
//  dst_valid  in   1      / dst_data in DW  / dst_last in 1  / dst_ready out 1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/bases 0. Reset mid-operation aborts at once;
//   src_valid/dst_ready are 0 while rst_n low; RAM contents undefined afterwards.
//  States: IDLE -start-> SEND -last src beat-> RECV -last dst beat-> (more samples ? SEND : DONE)
//   DONE -> IDLE after 1 cycle (done=1 in DONE). RECV -timeout-> ERR -> IDLE (err set, no done).
//  start ignored unless IDLE; ss/ds/n_batch latched on accepted start.
//  Transfer = valid&ready same posedge. src_valid, once high, stays high and src_data/src_last
//   stay stable until accepted. src RAM read latency 1: one-entry output register plus prefetch
//   gives back-to-back beats when src_ready held high (first src_valid 2 cycles after start).
//  Sample k sends src RAM words sbase..sbase+ss; src_last=1 only on word ss. sbase starts 0,
//   += ss+1 per sample. ss=0 -> single beat with src_last=1.
//  RECV: dst_ready=1; each dst beat writes result RAM[rbase+cnt]; after cnt==ds dst_ready drops
//   same edge. rbase starts 0, += ds+1 per sample. dst_ready=0 outside RECV.
//  dst_last is ignored; result length is set by ds only.
//  Address arithmetic modulo 2**AW (4095+1 wraps to 0); no overflow flag.
//  h_wr ignored while busy; h_rd always honoured (reads result RAM in all states).
//  Same-cycle h_rd and dst write to same address: h_rdata returns old word.
// CONFIGURATION
//  TDNN_TIMEOUT_EN defined: cycle counter clears on each dst beat and on RECV entry; reaching
//   TIMEOUT_CYC in RECV sets err, state ERR, dst_ready=0.
//  Undefined: no counter, err tied 0, RECV waits indefinitely.
// STRUCTURE
//  Package tiny_dnn_pkg: typedef word_t (logic [DW-1:0]), addr_t, enum sm_state_t
//   {IDLE,SEND,RECV,DONE,ERR}, constant default TIMEOUT_CYC.
//  Sub-module tdnn_word_ram: 1 write + 1 registered read port, instantiated twice (src, result).
// TESTING
//  1 write src[0..3]=1.0,2.0,3.0,4.0; ss=3,ds=1,n_batch=0; src_ready=1 -> 4 consecutive beats,
//    src_last on 4.0 only; feed dst 0.5,0.25 -> result[0..1]=0.5,0.25, done pulses once, busy 0.
//  2 same stimulus, src_ready toggles 1/0 each cycle -> data/last held stable while stalled,
//    order and count unchanged.
//  3 n_batch=1, ss=1, src[0..3]=A,B,C,D; ds=0 -> src bursts {A,B},{C,D}, each followed by one
//    dst beat; results at result[0],[1].
//  4 second start while busy, h_wr during SEND -> start ignored, src RAM unchanged.
//  5 rst_n low during SEND beat 2 -> src_valid 0 immediately; after release busy=0, next start works.
//  6 TDNN_TIMEOUT_EN, TIMEOUT_CYC=16, no dst_valid -> err=1 after 16 RECV cycles, done never, busy 0.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// ---------------------------------------------------------------------------
// tiny_dnn_pkg
// Shared types and defaults for the tiny_dnn stream master and its RAMs.
//   word_t      : one data word (IEEE-754 single bit pattern)
//   addr_t      : one RAM word address
//   sm_state_t  : controller state encoding
//   TIMEOUT_CYC_DEF : default RECV idle limit (used when TDNN_TIMEOUT_EN is defined)
// ---------------------------------------------------------------------------
package tiny_dnn_pkg;

    localparam int AW_DEF          = 12;
    localparam int DW_DEF          = 32;
    localparam int TIMEOUT_CYC_DEF = 65535;

    typedef logic [DW_DEF-1:0] word_t;
    typedef logic [AW_DEF-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        RECV = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } sm_state_t;

endpackage

// File: rtl/tdnn_word_ram.sv
// ---------------------------------------------------------------------------
// tdnn_word_ram
// Simple dual-port word RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
// Ports:
//   clk, rst_n        clock / async active-low reset (read register only)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr           read enable / address; o_rdata updates only when i_re
//   o_rdata           registered read data (0 in reset)
// ---------------------------------------------------------------------------
module tdnn_word_ram
    import tiny_dnn_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read data holds when not enabled; the stream master relies on this as
    // its prefetch slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tiny_dnn_stream_master.sv
// ---------------------------------------------------------------------------
// tiny_dnn_stream_master
// Host-side stream endpoint for the tiny_dnn accelerator. The host fills the
// src RAM; on start each sample (ss+1 words) is sent as a src_* beat train,
// then ds+1 result words are collected from dst_* into the result RAM.
// Optional feature macro: TDNN_TIMEOUT_EN (RECV idle timeout -> err).
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   h_wr,h_rd,h_addr,h_wdata,h_rdata   host port (write src RAM, read result RAM)
//   start, ss, ds, n_batch        batch control, latched on accepted start
//   busy, done, err               status
//   src_valid,src_data,src_last,src_ready   outbound stream
//   dst_valid,dst_data,dst_last,dst_ready   inbound stream (dst_last unused)
//
// state | meaning
// IDLE  | waiting for start
// SEND  | streaming current sample from src RAM
// RECV  | collecting ds+1 result words
// DONE  | one-cycle done pulse
// ERR   | one-cycle exit after RECV timeout
// ---------------------------------------------------------------------------
module tiny_dnn_stream_master
    import tiny_dnn_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
`ifdef TDNN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          h_wr,
    input  logic          h_rd,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    input  logic          start,
    input  logic [AW-1:0] ss,
    input  logic [AW-1:0] ds,
    input  logic [7:0]    n_batch,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          src_valid,
    output logic [DW-1:0] src_data,
    output logic          src_last,
    input  logic          src_ready,
    input  logic          dst_valid,
    input  logic [DW-1:0] dst_data,
    input  logic          dst_last,
    output logic          dst_ready
);

    sm_state_t     r_state, w_next;
    logic [AW-1:0] r_ss, r_ds;
    logic [7:0]    r_nb, r_smp;
    logic [AW-1:0] r_sbase, r_rbase, r_dcnt, r_rd_idx;
    logic          r_rd_done, r_pend, r_pend_last;
    logic          r_src_valid, r_src_last;
    logic [DW-1:0] r_src_data;

    logic          w_busy, w_done, w_dst_ready;
    logic          w_start_acc, w_in_send, w_in_recv;
    logic          w_src_beat, w_src_fin, w_dst_beat, w_dst_fin;
    logic          w_load, w_issue, w_tmo;
    logic [AW-1:0] w_src_raddr, w_res_waddr;
    logic [DW-1:0] w_src_rdata;
    logic          w_unused;

    assign w_unused    = dst_last;

    assign w_in_send   = (r_state == SEND);
    assign w_in_recv   = (r_state == RECV);
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_src_beat  = r_src_valid && src_ready;
    assign w_src_fin   = w_src_beat && r_src_last;
    assign w_dst_beat  = w_in_recv && dst_valid;
    assign w_dst_fin   = w_dst_beat && (r_dcnt == r_ds);

    // The RAM read register is the prefetch slot (r_pend marks it full);
    // src_data is the output register. Move the slot forward whenever the
    // output is empty or being taken, and refill the slot in the same cycle.
    assign w_load      = w_in_send && r_pend && (!r_src_valid || src_ready);
    assign w_issue     = w_in_send && !r_rd_done && (!r_pend || w_load);
    assign w_src_raddr = r_sbase + r_rd_idx;
    assign w_res_waddr = r_rbase + r_dcnt;

`ifdef TDNN_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_err;

    assign w_tmo = w_in_recv && !w_dst_beat && (r_tmo_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (!w_in_recv || w_dst_beat) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            end
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_dst_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = SEND;
            end
            SEND: begin
                w_busy = 1'b1;
                if (w_src_fin) w_next = RECV;
            end
            RECV: begin
                w_busy      = 1'b1;
                w_dst_ready = 1'b1;
                if (w_dst_fin) begin
                    w_next = (r_smp == r_nb) ? DONE : SEND;
                end else if (w_tmo) begin
                    w_next = ERR;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Batch bookkeeping: config latch, sample/result bases, result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss    <= '0;
            r_ds    <= '0;
            r_nb    <= '0;
            r_smp   <= '0;
            r_sbase <= '0;
            r_rbase <= '0;
            r_dcnt  <= '0;
        end else begin
            if (w_start_acc) begin
                r_ss    <= ss;
                r_ds    <= ds;
                r_nb    <= n_batch;
                r_smp   <= '0;
                r_sbase <= '0;
                r_rbase <= '0;
                r_dcnt  <= '0;
            end else begin
                if (w_src_fin) begin
                    r_sbase <= r_sbase + r_ss + AW'(1);
                end
                if (w_dst_fin) begin
                    r_dcnt  <= '0;
                    r_rbase <= r_rbase + r_ds + AW'(1);
                    r_smp   <= r_smp + 8'd1;
                end else if (w_dst_beat) begin
                    r_dcnt  <= r_dcnt + AW'(1);
                end
            end
        end
    end

    // Source read pipeline; everything is cleared outside SEND so each
    // sample starts from a clean prefetch state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx    <= '0;
            r_rd_done   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_src_valid <= 1'b0;
            r_src_data  <= '0;
            r_src_last  <= 1'b0;
        end else if (!w_in_send) begin
            r_rd_idx    <= '0;
            r_rd_done   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_src_valid <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rd_idx    <= r_rd_idx + AW'(1);
                r_pend_last <= (r_rd_idx == r_ss);
                if (r_rd_idx == r_ss) begin
                    r_rd_done <= 1'b1;
                end
            end
            if (w_issue) begin
                r_pend <= 1'b1;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end
            if (w_load) begin
                r_src_valid <= 1'b1;
                r_src_data  <= w_src_rdata;
                r_src_last  <= r_pend_last;
            end else if (w_src_beat) begin
                r_src_valid <= 1'b0;
            end
        end
    end

    tdnn_word_ram #(.AW(AW), .DW(DW)) u_src_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (h_wr && !w_busy),
        .i_waddr (h_addr),
        .i_wdata (h_wdata),
        .i_re    (w_issue),
        .i_raddr (w_src_raddr),
        .o_rdata (w_src_rdata)
    );

    tdnn_word_ram #(.AW(AW), .DW(DW)) u_res_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_dst_beat),
        .i_waddr (w_res_waddr),
        .i_wdata (dst_data),
        .i_re    (h_rd),
        .i_raddr (h_addr),
        .o_rdata (h_rdata)
    );

    assign busy      = w_busy;
    assign done      = w_done;
    assign dst_ready = w_dst_ready;
    assign src_valid = r_src_valid;
    assign src_data  = r_src_data;
    assign src_last  = r_src_last;

endmodule

// File: tb/tb_tiny_dnn_stream_master.sv
module tb_tiny_dnn_stream_master;

    localparam int AW = 12;
    localparam int DW = 32;

    localparam logic [31:0] F1_0  = 32'h3F80_0000;
    localparam logic [31:0] F2_0  = 32'h4000_0000;
    localparam logic [31:0] F3_0  = 32'h4040_0000;
    localparam logic [31:0] F4_0  = 32'h4080_0000;
    localparam logic [31:0] F0_5  = 32'h3F00_0000;
    localparam logic [31:0] F0_25 = 32'h3E80_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          h_wr = 1'b0, h_rd = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic [DW-1:0] h_rdata;
    logic          start = 1'b0;
    logic [AW-1:0] ss = '0, ds = '0;
    logic [7:0]    n_batch = '0;
    logic          busy, done, err;
    logic          src_valid, src_last;
    logic [DW-1:0] src_data;
    logic          src_ready = 1'b0;
    logic          dst_valid = 1'b0, dst_last = 1'b0;
    logic [DW-1:0] dst_data = '0;
    logic          dst_ready;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } src_exp_t;

    src_exp_t    q_src[$];
    logic [31:0] q_dst[$];
    logic [31:0] q_res[$];

    tiny_dnn_stream_master #(
        .AW(AW),
        .DW(DW)
`ifdef TDNN_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .h_wr(h_wr), .h_rd(h_rd), .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata),
        .start(start), .ss(ss), .ds(ds), .n_batch(n_batch),
        .busy(busy), .done(done), .err(err),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks are entered and left at a negedge.
    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        h_wr = 1'b1; h_addr = a; h_wdata = d;
        @(negedge clk);
        h_wr = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        h_rd = 1'b1; h_addr = a;
        @(negedge clk);
        h_rd = 1'b0;
        d = h_rdata;
    endtask

    task automatic load_basic();
        host_write(12'd0, F1_0);
        host_write(12'd1, F2_0);
        host_write(12'd2, F3_0);
        host_write(12'd3, F4_0);
    endtask

    task automatic expect_basic();
        q_src.push_back({F1_0, 1'b0});
        q_src.push_back({F2_0, 1'b0});
        q_src.push_back({F3_0, 1'b0});
        q_src.push_back({F4_0, 1'b1});
        q_dst.push_back(F0_5);
        q_dst.push_back(F0_25);
        q_res.push_back(F0_5);
        q_res.push_back(F0_25);
    endtask

    // Starts a batch and services both streams until done; src beats and
    // result words are checked against the scoreboard queues.
    // mode: 0 ready always, 1 ready toggles, 2 ready random.
    task automatic run_batch(input logic [AW-1:0] ss_i, input logic [AW-1:0] ds_i,
                             input logic [7:0] nb_i, input int mode, input bit inject,
                             input int budget, output int first_v, output int last_v);
        int          done_cnt = 0;
        int          extra_rdy = 0;
        bit          fin = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic        prev_l = 1'b0;
        src_exp_t    e;
        logic [31:0] rd;
        first_v = -1;
        last_v  = -1;
        ss = ss_i; ds = ds_i; n_batch = nb_i;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++; $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int cyc = 1; cyc < budget && !fin; cyc++) begin
            if (inject && cyc == 4) begin
                start = 1'b1; h_wr = 1'b1; h_addr = '0; h_wdata = 32'hDEAD_BEEF;
            end else if (inject && cyc == 5) begin
                start = 1'b0; h_wr = 1'b0;
            end
            case (mode)
                0:       src_ready = 1'b1;
                1:       src_ready = cyc[0];
                default: src_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                n_vec++;
                if (src_valid !== 1'b1 || src_data !== prev_d || src_last !== prev_l) begin
                    n_miss++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             src_valid, src_data, src_last, prev_d, prev_l);
                end
            end
            if (src_valid === 1'b1 && src_ready) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                n_vec++;
                if (q_src.size() == 0) begin
                    n_miss++; $display("FAIL src_extra_beat: got d=%h want no beat", src_data);
                end else begin
                    e = q_src.pop_front();
                    if (src_data !== e.d || src_last !== e.l) begin
                        n_miss++;
                        $display("FAIL src_beat: got d=%h l=%b want d=%h l=%b",
                                 src_data, src_last, e.d, e.l);
                    end
                end
            end
            prev_stall = (src_valid === 1'b1) && !src_ready;
            prev_d = src_data;
            prev_l = src_last;
            dst_valid = 1'b0;
            if (dst_ready === 1'b1) begin
                if (q_dst.size() > 0) begin
                    dst_valid = 1'b1;
                    dst_data  = q_dst.pop_front();
                end else begin
                    extra_rdy++;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                fin = 1'b1;
            end
            @(negedge clk);
        end
        dst_valid = 1'b0;
        src_ready = 1'b0;
        n_vec++;
        if (!fin) begin
            n_miss++; $display("FAIL batch_timeout: got no done want done within %0d cycles", budget);
        end
        n_vec++;
        if (done_cnt != 1 || done !== 1'b0) begin
            n_miss++; $display("FAIL done_pulse: got count=%0d now=%b want 1 and 0", done_cnt, done);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++; $display("FAIL busy_after_done: got %b want 0", busy);
        end
        n_vec++;
        if (q_src.size() != 0 || q_dst.size() != 0) begin
            n_miss++; $display("FAIL beat_count: got src_left=%0d dst_left=%0d want 0 0",
                               q_src.size(), q_dst.size());
        end
        n_vec++;
        if (extra_rdy != 0) begin
            n_miss++; $display("FAIL dst_ready_drop: got %0d idle ready cycles want 0", extra_rdy);
        end
        q_src.delete();
        q_dst.delete();
        for (int i = 0; i < q_res.size(); i++) begin
            host_read(AW'(i), rd);
            n_vec++;
            if (rd !== q_res[i]) begin
                n_miss++; $display("FAIL result[%0d]: got %h want %h", i, rd, q_res[i]);
            end
        end
        q_res.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (src_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dst_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ctrl: got v=%b busy=%b done=%b err=%b rdy=%b want all 0",
                     src_valid, busy, done, err, dst_ready);
        end
        n_vec++;
        if (src_data !== '0 || src_last !== 1'b0 || h_rdata !== '0) begin
            n_miss++;
            $display("FAIL reset_data: got src=%h last=%b rdata=%h want 0", src_data, src_last, h_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_sample();
        int f, l;
        load_basic();
        expect_basic();
        run_batch(12'd3, 12'd1, 8'd0, 0, 1'b0, 200, f, l);
        n_vec++;
        if (f != 3) begin
            n_miss++; $display("FAIL first_valid_latency: got %0d want 3", f);
        end
        n_vec++;
        if (l - f != 3) begin
            n_miss++; $display("FAIL back_to_back: got span %0d want 3", l - f);
        end
    endtask

    task automatic test_stall();
        int f, l;
        load_basic();
        expect_basic();
        run_batch(12'd3, 12'd1, 8'd0, 1, 1'b0, 200, f, l);
        expect_basic();
        run_batch(12'd3, 12'd1, 8'd0, 2, 1'b0, 200, f, l);
    endtask

    task automatic test_multi_sample();
        int f, l;
        host_write(12'd0, 32'hAAAA_0001);
        host_write(12'd1, 32'hBBBB_0002);
        host_write(12'd2, 32'hCCCC_0003);
        host_write(12'd3, 32'hDDDD_0004);
        q_src.push_back({32'hAAAA_0001, 1'b0});
        q_src.push_back({32'hBBBB_0002, 1'b1});
        q_src.push_back({32'hCCCC_0003, 1'b0});
        q_src.push_back({32'hDDDD_0004, 1'b1});
        q_dst.push_back(32'h1111_1111);
        q_dst.push_back(32'h2222_2222);
        q_res.push_back(32'h1111_1111);
        q_res.push_back(32'h2222_2222);
        run_batch(12'd1, 12'd0, 8'd1, 0, 1'b0, 200, f, l);
    endtask

    task automatic test_busy_ignore();
        int f, l;
        load_basic();
        expect_basic();
        run_batch(12'd3, 12'd1, 8'd0, 0, 1'b1, 200, f, l);
        expect_basic();
        run_batch(12'd3, 12'd1, 8'd0, 0, 1'b0, 200, f, l);
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        bit hit = 1'b0;
        int f, l;
        load_basic();
        ss = 12'd3; ds = 12'd1; n_batch = 8'd0;
        src_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 20 && !hit; cyc++) begin
            if (src_valid === 1'b1 && beats == 1) begin
                hit = 1'b1;
            end else begin
                if (src_valid === 1'b1) beats++;
                @(negedge clk);
            end
        end
        n_vec++;
        if (!hit) begin
            n_miss++; $display("FAIL reach_beat2: got beats=%0d want beat 2 presented", beats);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (src_valid !== 1'b0 || busy !== 1'b0 || dst_ready !== 1'b0) begin
            n_miss++; $display("FAIL reset_abort: got v=%b busy=%b rdy=%b want 0 0 0",
                               src_valid, busy, dst_ready);
        end
        src_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || src_valid !== 1'b0) begin
            n_miss++; $display("FAIL after_reset_idle: got busy=%b v=%b want 0 0", busy, src_valid);
        end
        load_basic();
        expect_basic();
        run_batch(12'd3, 12'd1, 8'd0, 0, 1'b0, 200, f, l);
    endtask

    task automatic test_timeout();
        int rdy_cnt = 0;
        int done_cnt = 0;
        bit hit = 1'b0;
        logic [31:0] rd;
        host_write(12'd0, F1_0);
        ss = 12'd0; ds = 12'd0; n_batch = 8'd0;
        src_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef TDNN_TIMEOUT_EN
        for (int cyc = 1; cyc < 60 && !hit; cyc++) begin
            if (err === 1'b1) begin
                hit = 1'b1;
            end else begin
                if (dst_ready === 1'b1) rdy_cnt++;
                if (done === 1'b1) done_cnt++;
                @(negedge clk);
            end
        end
        src_ready = 1'b0;
        n_vec++;
        if (!hit || rdy_cnt != 16) begin
            n_miss++; $display("FAIL timeout_cycles: got err=%b recv=%0d want err=1 recv=16", err, rdy_cnt);
        end
        n_vec++;
        if (done_cnt != 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_miss++; $display("FAIL timeout_status: got done_cnt=%0d busy=%b want 0 0", done_cnt, busy);
        end
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_miss++; $display("FAIL err_sticky: got err=%b busy=%b want 1 0", err, busy);
        end
        test_single_sample();
        n_vec++;
        if (err !== 1'b0) begin
            n_miss++; $display("FAIL err_clear: got %b want 0", err);
        end
`else
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (dst_ready === 1'b1) rdy_cnt++;
            if (err === 1'b1) hit = 1'b1;
            @(negedge clk);
        end
        src_ready = 1'b0;
        n_vec++;
        if (hit || err !== 1'b0 || busy !== 1'b1 || dst_ready !== 1'b1 || rdy_cnt != 36) begin
            n_miss++; $display("FAIL recv_wait: got err=%b busy=%b rdy=%b cnt=%0d want 0 1 1 36",
                               err, busy, dst_ready, rdy_cnt);
        end
        dst_valid = 1'b1;
        dst_data  = 32'h7777_0001;
        @(negedge clk);
        dst_valid = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_miss++; $display("FAIL late_beat_done: got %b want 1", done);
        end
        @(negedge clk);
        host_read(12'd0, rd);
        n_vec++;
        if (rd !== 32'h7777_0001 || busy !== 1'b0) begin
            n_miss++; $display("FAIL late_beat_result: got %h busy=%b want 77770001 0", rd, busy);
        end
`endif
    endtask

    task automatic test_wrap();
        int f, l;
        for (int i = 0; i < 4096; i++) begin
            host_write(AW'(i), 32'h1000_0000 + 32'(i));
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4096; i++) begin
                q_src.push_back({32'h1000_0000 + 32'(i), (i == 4095)});
            end
        end
        q_dst.push_back(32'h5555_0000);
        q_dst.push_back(32'h5555_0001);
        q_res.push_back(32'h5555_0000);
        q_res.push_back(32'h5555_0001);
        run_batch(12'd4095, 12'd0, 8'd1, 0, 1'b0, 20000, f, l);
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_stall();
        test_multi_sample();
        test_busy_ignore();
        test_reset_mid();
        test_timeout();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
